poli_sweep_ctrl: RTL

//  Upstream driver/characteriser for the POLI polymorphic-gate stage.

---
 rtl/poli_sweep_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/poli_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// poli_sweep_ctrl
//
// Upstream driver / characteriser for the POLI polymorphic-gate stage.
// Drives the gate's output_select, A, B, Vxx and Vyy pins, captures the
// gate output X through a two-flop synchroniser and assembles the measured
// truth tables. A run covers either one configuration (four {A,B} vectors)
// or all eight configurations. On completion the measured tables are
// compared with the host-supplied expected tables and pass/fail is reported.
//
// Parameters
//   SETTLE_CYCLES  cycles each drive pattern is held ahead of the sync stage
//                  (1..255); each pattern lasts P = SETTLE_CYCLES + 2 cycles
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   start       in   request a run, accepted only while idle
//   abort       in   synchronous cancel of a run in progress
//   sweep_all   in   1: all 8 configs, 0: single config from cfg_*
//   cfg_sel     in   output_select for a single run
//   cfg_vxx     in   Vxx level for a single run
//   cfg_vyy     in   Vyy level for a single run
//   exp_tables  in   expected tables, slot idx={sel,vxx,vyy} at [idx*4 +: 4]
//   poli_sel    out  POLI output_select
//   poli_a      out  POLI A
//   poli_b      out  POLI B
//   poli_vxx    out  POLI Vxx
//   poli_vyy    out  POLI Vyy
//   poli_x      in   POLI X, asynchronous to clk
//   busy        out  run in progress
//   done        out  one-cycle pulse, result/pass valid
//   pass        out  all measured slots matched, held until next accepted start
//   result      out  measured tables, same layout as exp_tables
// -----------------------------------------------------------------------------
module poli_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic        abort,
   input  logic        sweep_all,
   input  logic        cfg_sel,
   input  logic        cfg_vxx,
   input  logic        cfg_vyy,
   input  logic [31:0] exp_tables,
   output logic        poli_sel,
   output logic        poli_a,
   output logic        poli_b,
   output logic        poli_vxx,
   output logic        poli_vyy,
   input  logic        poli_x,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] result
);

   localparam int unsigned Period = SETTLE_CYCLES + 2;
   // Eight bits cover every period except SETTLE_CYCLES=255, where the
   // terminal count (P-1 = 256) needs one more bit.
   localparam int unsigned CntW = (Period > 256) ? 9 : 8;
   localparam logic [CntW-1:0] CntLast = CntW'(Period - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        vec_q, vec_d;
   logic [2:0]        idx_q, idx_d;
   logic              sweep_q, sweep_d;
   logic [31:0]       exp_q, exp_d;
   logic [31:0]       result_q, result_d;
   logic              pass_q, pass_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [4:0]        pins_q, pins_d;   // {sel, vxx, vyy, a, b}
   logic [1:0]        sync_q, sync_d;
   logic              last_vec;

   // Two-flop synchroniser for the asynchronous gate output.
   always_comb begin
      sync_d = {sync_q[0], poli_x};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      vec_d    = vec_q;
      idx_d    = idx_q;
      sweep_d  = sweep_q;
      exp_d    = exp_q;
      result_d = result_q;
      pass_d   = pass_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      last_vec = (vec_q == 2'd3) && (!sweep_q || (idx_q == 3'd7));

      case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d  = StRun;
               sweep_d  = sweep_all;
               idx_d    = sweep_all ? 3'd0 : {cfg_sel, cfg_vxx, cfg_vyy};
               vec_d    = 2'd0;
               cnt_d    = '0;
               exp_d    = exp_tables;
               result_d = '0;
               pass_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end

         StRun: begin
            if (abort) begin
               // Abort beats a coinciding final sample: no done pulse.
               state_d  = StIdle;
               busy_d   = 1'b0;
               result_d = '0;
               pass_d   = 1'b0;
               cnt_d    = '0;
               vec_d    = 2'd0;
               idx_d    = 3'd0;
            end else if (cnt_q == CntLast) begin
               // Sample edge: capture, then advance to the next pattern.
               result_d[{idx_q, vec_q}] = sync_q[1];
               cnt_d = '0;
               if (last_vec) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  // Unmeasured slots are zero and take no part in pass.
                  if (sweep_q) begin
                     pass_d = (result_d == exp_q);
                  end else begin
                     pass_d = (result_d[{idx_q, 2'b00} +: 4] == exp_q[{idx_q, 2'b00} +: 4]);
                  end
                  vec_d = 2'd0;
                  idx_d = 3'd0;
               end else begin
                  vec_d = vec_q + 2'd1;
                  if (vec_q == 2'd3) begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase

      // Pins are registered from the next state so they change on the
      // same edge as the sample and are quiet outside a run.
      pins_d = (state_d == StRun) ? {idx_d, vec_d} : 5'd0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         vec_q    <= 2'd0;
         idx_q    <= 3'd0;
         sweep_q  <= 1'b0;
         exp_q    <= '0;
         result_q <= '0;
         pass_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pins_q   <= 5'd0;
         sync_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         vec_q    <= vec_d;
         idx_q    <= idx_d;
         sweep_q  <= sweep_d;
         exp_q    <= exp_d;
         result_q <= result_d;
         pass_q   <= pass_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pins_q   <= pins_d;
         sync_q   <= sync_d;
      end
   end

   assign poli_sel = pins_q[4];
   assign poli_vxx = pins_q[3];
   assign poli_vyy = pins_q[2];
   assign poli_a   = pins_q[1];
   assign poli_b   = pins_q[0];
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign result   = result_q;

endmodule
